// File: rtl/aes_fifo_sequencer.sv
// AES-256 FIFO sequencer: seed load, key generation, then per-command block encrypt/decrypt and store.
// Optional KG_WAIT/RUN watchdog is enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_fifo_sequencer #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned SEED_WORDS = 8,
    parameter int unsigned BLK_WORDS  = 4,
    parameter int unsigned TMO_CYC    = 4096
) (
    input  logic                         s00_axi_aclk,
    input  logic                         s00_axi_aresetn,
    input  logic                         seed_empty,
    input  logic [WORD_W-1:0]            seed_data,
    output logic                         seed_rd,
    input  logic                         din_empty,
    input  logic [WORD_W-1:0]            din_data,
    output logic                         din_rd,
    input  logic                         dout_full,
    output logic                         dout_wr,
    output logic [WORD_W-1:0]            dout_data,
    input  logic                         ctrl_wr,
    input  logic [1:0]                   ctrl_data,
    output logic                         kg_start,
    output logic [SEED_WORDS*WORD_W-1:0] kg_seed,
    input  logic                         kg_done,
    output logic                         aes_start,
    output logic                         aes_decrypt,
    output logic [BLK_WORDS*WORD_W-1:0]  aes_block,
    input  logic                         aes_done,
    input  logic [BLK_WORDS*WORD_W-1:0]  aes_result,
    output logic [31:0]                  reg_status
);
    localparam int unsigned SEED_W = SEED_WORDS * WORD_W;
    localparam int unsigned BLK_W  = BLK_WORDS * WORD_W;
    localparam int unsigned CNT_W  = $clog2((SEED_WORDS > BLK_WORDS) ? SEED_WORDS : BLK_WORDS);
    localparam logic [CNT_W-1:0] SEED_LAST = CNT_W'(SEED_WORDS - 1);
    localparam logic [CNT_W-1:0] BLK_LAST  = CNT_W'(BLK_WORDS - 1);

    typedef enum logic [2:0] {IDLE, LD_SEED, KG_WAIT, READY, LD_BLK, RUN, STORE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEED_W-1:0]  seed_q, seed_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [BLK_W-1:0]   res_q, res_d;
    logic               kg_start_q, kg_start_d;
    logic               aes_start_q, aes_start_d;
    logic               dec_q, dec_d;
    logic               enc_busy_q, enc_busy_d;
    logic               dec_busy_q, dec_busy_d;
    logic               kg_fin_q, kg_fin_d;
    logic               cmd_ok;
    logic               tmo_hit;
    logic               tmo_err;

    assign cmd_ok = ctrl_wr && kg_fin_q && (ctrl_data == 2'b01 || ctrl_data == 2'b10);

    // State and datapath registers
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            seed_q      <= '0;
            blk_q       <= '0;
            res_q       <= '0;
            kg_start_q  <= 1'b0;
            aes_start_q <= 1'b0;
            dec_q       <= 1'b0;
            enc_busy_q  <= 1'b0;
            dec_busy_q  <= 1'b0;
            kg_fin_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            blk_q       <= blk_d;
            res_q       <= res_d;
            kg_start_q  <= kg_start_d;
            aes_start_q <= aes_start_d;
            dec_q       <= dec_d;
            enc_busy_q  <= enc_busy_d;
            dec_busy_q  <= dec_busy_d;
            kg_fin_q    <= kg_fin_d;
        end
    end

    // Next-state, FIFO handshakes and register updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seed_d      = seed_q;
        blk_d       = blk_q;
        res_d       = res_q;
        kg_start_d  = 1'b0;
        aes_start_d = 1'b0;
        dec_d       = dec_q;
        enc_busy_d  = enc_busy_q;
        dec_busy_d  = dec_busy_q;
        kg_fin_d    = kg_fin_q;
        seed_rd     = 1'b0;
        din_rd      = 1'b0;
        dout_wr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!seed_empty) begin
                    state_d  = LD_SEED;
                    cnt_d    = '0;
                    kg_fin_d = 1'b0;
                end
            end
            LD_SEED: begin
                if (!seed_empty) begin
                    seed_rd = 1'b1;
                    seed_d  = {seed_q[SEED_W-WORD_W-1:0], seed_data};
                    if (cnt_q == SEED_LAST) begin
                        cnt_d      = '0;
                        kg_start_d = 1'b1;
                        state_d    = KG_WAIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            KG_WAIT: begin
                if (kg_done) begin
                    kg_fin_d = 1'b1;
                    state_d  = READY;
                end else if (tmo_hit) begin
                    kg_fin_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            READY: begin
                // A valid command wins over newly arrived seed data
                if (cmd_ok) begin
                    enc_busy_d = (ctrl_data == 2'b01);
                    dec_busy_d = (ctrl_data == 2'b10);
                    dec_d      = ctrl_data[1];
                    cnt_d      = '0;
                    state_d    = LD_BLK;
                end else if (!seed_empty) begin
                    kg_fin_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = LD_SEED;
                end
            end
            LD_BLK: begin
                if (!din_empty) begin
                    din_rd = 1'b1;
                    blk_d  = {blk_q[BLK_W-WORD_W-1:0], din_data};
                    if (cnt_q == BLK_LAST) begin
                        cnt_d       = '0;
                        aes_start_d = 1'b1;
                        state_d     = RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RUN: begin
                if (aes_done) begin
                    res_d   = aes_result;
                    cnt_d   = '0;
                    state_d = STORE;
                end else if (tmo_hit) begin
                    enc_busy_d = 1'b0;
                    dec_busy_d = 1'b0;
                    kg_fin_d   = 1'b0;
                    state_d    = IDLE;
                end
            end
            STORE: begin
                if (!dout_full) begin
                    dout_wr = 1'b1;
                    res_d   = res_q << WORD_W;
                    if (cnt_q == BLK_LAST) begin
                        cnt_d      = '0;
                        enc_busy_d = 1'b0;
                        dec_busy_d = 1'b0;
                        state_d    = READY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYC);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_err_q;
    logic             waiting;

    assign waiting = (state_q == KG_WAIT) || (state_q == RUN);
    assign tmo_hit = waiting && (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
    assign tmo_err = tmo_err_q;

    // Watchdog: a done arriving on the terminal cycle still wins
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (waiting && !tmo_hit) ? tmo_cnt_q + TMO_W'(1) : '0;
            if (tmo_hit && ((state_q == KG_WAIT && !kg_done) || (state_q == RUN && !aes_done)))
                tmo_err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo_err = 1'b0;
`endif

    assign kg_start    = kg_start_q;
    assign kg_seed     = seed_q;
    assign aes_start   = aes_start_q;
    assign aes_decrypt = dec_q;
    assign aes_block   = blk_q;
    assign dout_data   = (state_q == STORE) ? res_q[BLK_W-1 -: WORD_W] : '0;
    assign reg_status  = {28'd0, tmo_err, kg_fin_q, dec_busy_q, enc_busy_q};

endmodule

// File: tb/tb_aes_fifo_sequencer.sv
// Directed bench for aes_fifo_sequencer with show-ahead FIFO models; define AES_SEQ_TIMEOUT_EN for the watchdog test.
module tb_aes_fifo_sequencer;
    localparam int unsigned TMO_CYC = 4096;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         seed_empty, seed_rd, din_empty, din_rd, dout_full, dout_wr;
    logic [31:0]  seed_data, din_data, dout_data, reg_status;
    logic         ctrl_wr, kg_start, kg_done, aes_start, aes_decrypt, aes_done;
    logic [1:0]   ctrl_data;
    logic [255:0] kg_seed;
    logic [127:0] aes_block, aes_result;

    int checks = 0;
    int errors = 0;
    logic [31:0] seed_fifo[$];
    logic [31:0] din_fifo[$];
    logic [31:0] outq[$];
    int seed_pops = 0, din_pops = 0, kg_starts = 0, aes_starts = 0;

    aes_fifo_sequencer dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .seed_empty(seed_empty), .seed_data(seed_data), .seed_rd(seed_rd),
        .din_empty(din_empty), .din_data(din_data), .din_rd(din_rd),
        .dout_full(dout_full), .dout_wr(dout_wr), .dout_data(dout_data),
        .ctrl_wr(ctrl_wr), .ctrl_data(ctrl_data),
        .kg_start(kg_start), .kg_seed(kg_seed), .kg_done(kg_done),
        .aes_start(aes_start), .aes_decrypt(aes_decrypt), .aes_block(aes_block),
        .aes_done(aes_done), .aes_result(aes_result), .reg_status(reg_status)
    );

    always #5 clk = ~clk;

    // FIFO pops and output capture on the active edge (pre-update values)
    always @(posedge clk) begin
        if (seed_rd) begin
            seed_pops++;
            if (seed_fifo.size() > 0) void'(seed_fifo.pop_front());
        end
        if (din_rd) begin
            din_pops++;
            if (din_fifo.size() > 0) void'(din_fifo.pop_front());
        end
        if (dout_wr) outq.push_back(dout_data);
        if (kg_start) kg_starts++;
        if (aes_start) aes_starts++;
    end

    // Show-ahead heads presented on the falling edge
    always @(negedge clk) begin
        seed_empty = (seed_fifo.size() == 0);
        seed_data  = seed_empty ? 32'h0 : seed_fifo[0];
        din_empty  = (din_fifo.size() == 0);
        din_data   = din_empty ? 32'h0 : din_fifo[0];
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ctrl(input logic [1:0] v);
        @(negedge clk); ctrl_wr = 1'b1; ctrl_data = v;
        @(negedge clk); ctrl_wr = 1'b0; ctrl_data = 2'b00;
    endtask

    task automatic pulse_kg();
        @(negedge clk); kg_done = 1'b1;
        @(negedge clk); kg_done = 1'b0;
    endtask

    task automatic pulse_aes(input logic [127:0] r);
        @(negedge clk); aes_done = 1'b1; aes_result = r;
        @(negedge clk); aes_done = 1'b0; aes_result = '0;
    endtask

    task automatic push_seed_abcd();
        repeat (2) begin
            seed_fifo.push_back(32'hAAAAAAAA); seed_fifo.push_back(32'hBBBBBBBB);
            seed_fifo.push_back(32'hCCCCCCCC); seed_fifo.push_back(32'hDDDDDDDD);
        end
    endtask

    task automatic wait_kg_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin @(negedge clk); if (kg_start) ok = 1'b1; end
    endtask

    task automatic wait_aes_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin @(negedge clk); if (aes_start) ok = 1'b1; end
    endtask

    task automatic wait_out(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin @(negedge clk); if (outq.size() >= n) ok = 1'b1; end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (reg_status !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", reg_status); end
        checks++; if ({seed_rd, din_rd, dout_wr, kg_start, aes_start, aes_decrypt} !== 6'b0) begin
            errors++; $display("FAIL reset_ctl got %b exp 000000", {seed_rd, din_rd, dout_wr, kg_start, aes_start, aes_decrypt}); end
        checks++; if (kg_seed !== 256'h0 || aes_block !== 128'h0 || dout_data !== 32'h0) begin
            errors++; $display("FAIL reset_data seed %h blk %h dout %h exp 0", kg_seed, aes_block, dout_data); end
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_seed();
        bit ok;
        int p0 = seed_pops;
        int k0 = kg_starts;
        push_seed_abcd();
        wait_kg_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL seed_kg_start got none exp pulse"); end
        checks++; if (kg_seed !== 256'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD_AAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD) begin
            errors++; $display("FAIL seed_value got %h", kg_seed); end
        cyc(3);
        checks++; if (seed_pops - p0 != 8) begin errors++; $display("FAIL seed_pops got %0d exp 8", seed_pops - p0); end
        checks++; if (kg_starts - k0 != 1) begin errors++; $display("FAIL seed_kg_pulses got %0d exp 1", kg_starts - k0); end
        checks++; if (reg_status !== 32'h0) begin errors++; $display("FAIL seed_status_pre got %h exp 0", reg_status); end
        pulse_kg();
        checks++; if (reg_status !== 32'h4) begin errors++; $display("FAIL seed_status_fin got %h exp 4", reg_status); end
    endtask

    task automatic test_encrypt();
        bit ok;
        logic [127:0] exp_r = 128'hdeae1a89_b07f6e26_246b3283_cef7b78c;
        outq.delete();
        din_fifo.push_back(32'h00010203); din_fifo.push_back(32'h04050607);
        din_fifo.push_back(32'h08090a0b); din_fifo.push_back(32'h0c0d0e0f);
        cyc(1);
        pulse_ctrl(2'b01);
        checks++; if (reg_status !== 32'h5) begin errors++; $display("FAIL enc_status_busy got %h exp 5", reg_status); end
        wait_aes_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL enc_aes_start got none exp pulse"); end
        checks++; if (aes_block !== 128'h00010203_04050607_08090a0b_0c0d0e0f) begin
            errors++; $display("FAIL enc_block got %h", aes_block); end
        checks++; if (aes_decrypt !== 1'b0) begin errors++; $display("FAIL enc_decrypt got %b exp 0", aes_decrypt); end
        cyc(2);
        pulse_aes(exp_r);
        wait_out(4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL enc_out_count got %0d exp 4", outq.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (outq[i] !== exp_r[127-32*i -: 32]) begin
                errors++; $display("FAIL enc_word%0d got %h exp %h", i, outq[i], exp_r[127-32*i -: 32]); end
        end
        checks++; if (reg_status !== 32'h4) begin errors++; $display("FAIL enc_status_done got %h exp 4", reg_status); end
    endtask

    task automatic test_decrypt_stall();
        bit ok;
        int d0 = din_pops;
        int a0 = aes_starts;
        logic [127:0] exp_r = 128'h01234567_89abcdef_fedcba98_76543210;
        outq.delete();
        din_fifo.push_back(32'h11111111); din_fifo.push_back(32'h22222222);
        cyc(1);
        pulse_ctrl(2'b10);
        checks++; if (reg_status !== 32'h6) begin errors++; $display("FAIL dec_status_busy got %h exp 6", reg_status); end
        cyc(6);
        checks++; if (din_pops - d0 != 2) begin errors++; $display("FAIL dec_stall_pops got %0d exp 2", din_pops - d0); end
        checks++; if (aes_starts != a0 || reg_status !== 32'h6) begin
            errors++; $display("FAIL dec_stall starts %0d status %h exp 0 and 6", aes_starts - a0, reg_status); end
        din_fifo.push_back(32'h33333333); din_fifo.push_back(32'h44444444);
        wait_aes_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL dec_aes_start got none exp pulse"); end
        checks++; if (aes_decrypt !== 1'b1) begin errors++; $display("FAIL dec_decrypt got %b exp 1", aes_decrypt); end
        checks++; if (aes_block !== 128'h11111111_22222222_33333333_44444444) begin
            errors++; $display("FAIL dec_block got %h", aes_block); end
        dout_full = 1'b1;
        pulse_aes(exp_r);
        for (int i = 0; i < 3; i++) begin
            checks++; if (dout_wr !== 1'b0) begin errors++; $display("FAIL dec_full_hold cyc%0d got %b exp 0", i, dout_wr); end
            @(negedge clk);
        end
        checks++; if (outq.size() != 0) begin errors++; $display("FAIL dec_full_pushes got %0d exp 0", outq.size()); end
        dout_full = 1'b0;
        wait_out(4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL dec_out_count got %0d exp 4", outq.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (outq[i] !== exp_r[127-32*i -: 32]) begin
                errors++; $display("FAIL dec_word%0d got %h exp %h", i, outq[i], exp_r[127-32*i -: 32]); end
        end
        checks++; if (reg_status !== 32'h4) begin errors++; $display("FAIL dec_status_done got %h exp 4", reg_status); end
    endtask

    task automatic test_ignored();
        bit ok;
        int o0 = outq.size();
        int d0 = din_pops;
        pulse_aes(128'hffffffff_eeeeeeee_dddddddd_cccccccc);
        pulse_kg();
        cyc(2);
        checks++; if (outq.size() != o0 || reg_status !== 32'h4) begin
            errors++; $display("FAIL ign_spurious pushes %0d status %h exp 0 and 4", outq.size() - o0, reg_status); end
        din_fifo.push_back(32'h55555555); din_fifo.push_back(32'h66666666);
        din_fifo.push_back(32'h77777777); din_fifo.push_back(32'h88888888);
        cyc(1);
        pulse_ctrl(2'b11);
        pulse_ctrl(2'b00);
        cyc(3);
        checks++; if (reg_status !== 32'h4 || din_pops != d0) begin
            errors++; $display("FAIL ign_bad_cmd status %h pops %0d exp 4 and 0", reg_status, din_pops - d0); end
        pulse_ctrl(2'b01);
        wait_aes_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ign_aes_start got none exp pulse"); end
        pulse_ctrl(2'b10);
        cyc(20);
        checks++; if (reg_status !== 32'h5 || aes_decrypt !== 1'b0) begin
            errors++; $display("FAIL ign_run_cmd status %h dec %b exp 5 and 0", reg_status, aes_decrypt); end
        o0 = outq.size();
        pulse_aes(128'h0);
        wait_out(o0 + 4, ok);
        checks++; if (!ok || reg_status !== 32'h4) begin
            errors++; $display("FAIL ign_run_drain status %h outs %0d exp 4 and 4", reg_status, outq.size() - o0); end
        d0 = din_pops;
        din_fifo.push_back(32'h99999999);
        push_seed_abcd();
        wait_kg_start(ok);
        pulse_ctrl(2'b01);
        cyc(2);
        checks++; if (!ok || reg_status !== 32'h0 || din_pops != d0) begin
            errors++; $display("FAIL ign_pre_kg status %h pops %0d exp 0 and 0", reg_status, din_pops - d0); end
        pulse_kg();
        checks++; if (reg_status !== 32'h4) begin errors++; $display("FAIL ign_rekey got %h exp 4", reg_status); end
        din_fifo.delete();
        cyc(1);
    endtask

    task automatic test_reset_mid_op();
        int d0, a0;
        din_fifo.push_back(32'haaaa0001); din_fifo.push_back(32'haaaa0002);
        cyc(1);
        pulse_ctrl(2'b01);
        cyc(3);
        checks++; if (reg_status !== 32'h5) begin errors++; $display("FAIL rst_pre_status got %h exp 5", reg_status); end
        rst_n = 1'b0;
        cyc(1);
        checks++; if (reg_status !== 32'h0 || aes_block !== 128'h0 || kg_seed !== 256'h0 || dout_data !== 32'h0) begin
            errors++; $display("FAIL rst_mid_data status %h blk %h exp 0", reg_status, aes_block); end
        checks++; if ({seed_rd, din_rd, dout_wr, kg_start, aes_start, aes_decrypt} !== 6'b0) begin
            errors++; $display("FAIL rst_mid_ctl got %b exp 000000", {seed_rd, din_rd, dout_wr, kg_start, aes_start, aes_decrypt}); end
        din_fifo.delete();
        rst_n = 1'b1;
        cyc(2);
        din_fifo.push_back(32'h1); din_fifo.push_back(32'h2);
        din_fifo.push_back(32'h3); din_fifo.push_back(32'h4);
        cyc(1);
        d0 = din_pops;
        a0 = aes_starts;
        pulse_ctrl(2'b01);
        cyc(5);
        checks++; if (reg_status !== 32'h0 || din_pops != d0 || aes_starts != a0) begin
            errors++; $display("FAIL rst_cmd_ignored status %h pops %0d exp 0 and 0", reg_status, din_pops - d0); end
        din_fifo.delete();
        cyc(1);
    endtask

`ifdef AES_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        push_seed_abcd();
        wait_kg_start(ok);
        pulse_kg();
        din_fifo.push_back(32'h1); din_fifo.push_back(32'h2);
        din_fifo.push_back(32'h3); din_fifo.push_back(32'h4);
        cyc(1);
        pulse_ctrl(2'b01);
        wait_aes_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_aes_start got none exp pulse"); end
        cyc(TMO_CYC + 5);
        checks++; if (reg_status !== 32'h8) begin errors++; $display("FAIL tmo_status got %h exp 8", reg_status); end
        pulse_ctrl(2'b01);
        cyc(2);
        checks++; if (reg_status !== 32'h8) begin errors++; $display("FAIL tmo_sticky got %h exp 8", reg_status); end
    endtask
`endif

    initial begin
        seed_empty = 1'b1; seed_data = '0; din_empty = 1'b1; din_data = '0;
        dout_full = 1'b0; ctrl_wr = 1'b0; ctrl_data = 2'b00;
        kg_done = 1'b0; aes_done = 1'b0; aes_result = '0;
        test_reset();
        test_seed();
        test_encrypt();
        test_decrypt_stall();
        test_ignored();
        test_reset_mid_op();
`ifdef AES_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
